// File: rtl/rvfi_imem_coherence_check.sv
// ---------------------------------------------------------------------------
// rvfi_imem_coherence_check
//
// Instruction-memory coherence checker for an RVFI retire port.
//
// The checker tracks NSLOTS halfword addresses. For each slot:
//   - The first live retirement that covers the slot records (learns) the
//     instruction halfword it fetched there.
//   - Every later covering retirement must fetch the same halfword. If it
//     does not, the slot's mismatch flag is set and stays set.
//   - A store that writes either byte of the slot marks the slot stale.
//   - A FENCE.I re-arms a stale slot so that it can learn again.
// Because stores and FENCE.I are honoured, self-modifying code is checked
// correctly. A fixed-data check would report false mismatches on it.
//
// Retire channels are applied in ascending index order within a cycle.
// Each channel sees the slot state left by the lower channels. Within one
// channel the order is: cover, then store, then FENCE.I.
//
// Ports
//   clk             rising-edge clock
//   resetn          synchronous active-low reset
//   slot_addr       NSLOTS x XLEN tracked addresses (bit0 ignored)
//   rvfi_valid      per-channel retire valid
//   rvfi_insn       per-channel retired instruction (32 bits each)
//   rvfi_trap       per-channel trap flag
//   rvfi_pre_pc     per-channel PC of the retired instruction
//   rvfi_mem_addr   per-channel data memory address
//   rvfi_mem_wmask  per-channel store byte mask
//   slot_state      per slot 2 bits: 00 EMPTY, 01 LEARNED, 10 STALE
//   slot_data       per slot learned halfword
//   mismatch        per slot sticky mismatch flag
//   check_count     saturating number of compares performed
// ---------------------------------------------------------------------------
module rvfi_imem_coherence_check #(
  parameter int XLEN   = 32,
  parameter int NRET   = 1,
  parameter int NSLOTS = 2,
  parameter int CNTW   = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NSLOTS*XLEN-1:0]     slot_addr,
  input  logic [NRET-1:0]            rvfi_valid,
  input  logic [NRET*32-1:0]         rvfi_insn,
  input  logic [NRET-1:0]            rvfi_trap,
  input  logic [NRET*XLEN-1:0]       rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]       rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0]     rvfi_mem_wmask,
  output logic [NSLOTS*2-1:0]        slot_state,
  output logic [NSLOTS*16-1:0]       slot_data,
  output logic [NSLOTS-1:0]          mismatch,
  output logic [CNTW-1:0]            check_count
);

  localparam int NBYTES = XLEN / 8;
  // Wide enough to hold the current count plus every compare of one cycle.
  localparam int ACCW   = CNTW + $clog2(NRET * NSLOTS + 1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'b00,
    SLOT_LEARNED = 2'b01,
    SLOT_STALE   = 2'b10
  } slot_state_t;

  slot_state_t       state_q [NSLOTS];
  slot_state_t       state_d [NSLOTS];
  logic [15:0]       data_q  [NSLOTS];
  logic [15:0]       data_d  [NSLOTS];
  logic [NSLOTS-1:0] mismatch_q, mismatch_d, mismatch_set;
  logic [CNTW-1:0]   count_q, count_d;
  logic [ACCW-1:0]   compares, count_sum;

  // Tracked address for slot s, with bit0 cleared.
  function automatic logic [XLEN-1:0] slot_a(input int s);
    return slot_addr[s*XLEN +: XLEN] & ~XLEN'(1);
  endfunction

  // The halfword at pc, or the upper halfword of a 32-bit instruction at pc+2.
  function automatic logic covers_lo(input logic [XLEN-1:0] pc,
                                     input logic [XLEN-1:0] a);
    return pc == a;
  endfunction

  function automatic logic covers_hi(input logic [XLEN-1:0] pc,
                                     input logic [31:0]     insn,
                                     input logic [XLEN-1:0] a);
    return (insn[1:0] == 2'b11) && (pc + XLEN'(2) == a);
  endfunction

  // A store hits the slot if any enabled byte lands on A or A+1.
  function automatic logic store_hit(input logic [XLEN-1:0]   maddr,
                                     input logic [NBYTES-1:0] wmask,
                                     input logic [XLEN-1:0]   a);
    logic [XLEN-1:0] base;
    logic            hit;
    base = maddr & ~XLEN'(NBYTES - 1);
    hit  = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (wmask[i] && ((base + XLEN'(i) == a) || (base + XLEN'(i) == a + XLEN'(1))))
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_fence_i(input logic [31:0] insn);
    return (insn[6:0] == 7'b0001111) && (insn[14:12] == 3'b001);
  endfunction

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mismatch_set = '0;
    compares     = '0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c] && !rvfi_trap[c]) begin
        for (int s = 0; s < NSLOTS; s++) begin
          if (covers_lo(rvfi_pre_pc[c*XLEN +: XLEN], slot_a(s)) ||
              covers_hi(rvfi_pre_pc[c*XLEN +: XLEN], rvfi_insn[c*32 +: 32], slot_a(s))) begin
            // The two cover cases are exclusive, so the lo test selects H.
            logic [15:0] h;
            h = covers_lo(rvfi_pre_pc[c*XLEN +: XLEN], slot_a(s)) ?
                rvfi_insn[c*32 +: 16] : rvfi_insn[c*32+16 +: 16];
            case (state_d[s])
              SLOT_EMPTY: begin
                state_d[s] = SLOT_LEARNED;
                data_d[s]  = h;
              end
              SLOT_LEARNED: begin
                compares = compares + ACCW'(1);
                if (h != data_d[s]) mismatch_set[s] = 1'b1;
              end
              default: ;
            endcase
          end
          if (store_hit(rvfi_mem_addr[c*XLEN +: XLEN],
                        rvfi_mem_wmask[c*NBYTES +: NBYTES], slot_a(s)))
            state_d[s] = SLOT_STALE;
          if (is_fence_i(rvfi_insn[c*32 +: 32]) && state_d[s] == SLOT_STALE)
            state_d[s] = SLOT_EMPTY;
        end
      end
    end
    mismatch_d = mismatch_q | mismatch_set;
    count_sum  = ACCW'(count_q) + compares;
    count_d    = (count_sum > ACCW'(CNT_MAX)) ? CNT_MAX : count_sum[CNTW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // The per-slot arrays are a handful of flops, not a RAM, so clearing
      // them on reset is cheap and gives a defined post-reset state.
      for (int s = 0; s < NSLOTS; s++) begin
        state_q[s] <= SLOT_EMPTY;
        data_q[s]  <= '0;
      end
      mismatch_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mismatch_q <= mismatch_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    slot_state = '0;
    slot_data  = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      slot_state[s*2 +: 2] = state_q[s];
      slot_data[s*16 +: 16] = data_q[s];
    end
  end

  assign mismatch    = mismatch_q;
  assign check_count = count_q;

`ifdef FORMAL
  always_ff @(posedge clk) begin
    if (resetn) assert (!(|mismatch_set));
  end
`endif

endmodule

// File: tb/tb_rvfi_imem_coherence_check.sv
module tb_rvfi_imem_coherence_check;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] slot_addr;
  logic [1:0]  rvfi_valid, rvfi_trap;
  logic [63:0] rvfi_insn, rvfi_pre_pc, rvfi_mem_addr;
  logic [7:0]  rvfi_mem_wmask;

  logic [3:0]  slot_state;
  logic [31:0] slot_data;
  logic [1:0]  mismatch;
  logic [15:0] check_count;

  logic [3:0]  n1_state;
  logic [31:0] n1_data;
  logic [1:0]  n1_mismatch;
  logic [1:0]  n1_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0010_0093;
  localparam logic [31:0] SW     = 32'h0011_2023;
  localparam logic [31:0] FENCEI = 32'h0000_100F;

  always #5 clk = ~clk;

  rvfi_imem_coherence_check #(.XLEN(32), .NRET(2), .NSLOTS(2), .CNTW(16)) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .slot_addr      (slot_addr),
    .rvfi_valid     (rvfi_valid),
    .rvfi_insn      (rvfi_insn),
    .rvfi_trap      (rvfi_trap),
    .rvfi_pre_pc    (rvfi_pre_pc),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .slot_state     (slot_state),
    .slot_data      (slot_data),
    .mismatch       (mismatch),
    .check_count    (check_count)
  );

  // Single-channel instance with a 2-bit counter, fed from channel 0.
  rvfi_imem_coherence_check #(.XLEN(32), .NRET(1), .NSLOTS(2), .CNTW(2)) u_dut_n1 (
    .clk            (clk),
    .resetn         (resetn),
    .slot_addr      (slot_addr),
    .rvfi_valid     (rvfi_valid[0]),
    .rvfi_insn      (rvfi_insn[31:0]),
    .rvfi_trap      (rvfi_trap[0]),
    .rvfi_pre_pc    (rvfi_pre_pc[31:0]),
    .rvfi_mem_addr  (rvfi_mem_addr[31:0]),
    .rvfi_mem_wmask (rvfi_mem_wmask[3:0]),
    .slot_state     (n1_state),
    .slot_data      (n1_data),
    .mismatch       (n1_mismatch),
    .check_count    (n1_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rvfi_valid     = '0;
    rvfi_trap      = '0;
    rvfi_insn      = '0;
    rvfi_pre_pc    = '0;
    rvfi_mem_addr  = '0;
    rvfi_mem_wmask = '0;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic tr,
                        input logic [31:0] pc, input logic [31:0] insn,
                        input logic [31:0] maddr, input logic [3:0] wm);
    rvfi_valid[ch]           = v;
    rvfi_trap[ch]            = tr;
    rvfi_pre_pc[ch*32 +: 32] = pc;
    rvfi_insn[ch*32 +: 32]   = insn;
    rvfi_mem_addr[ch*32 +: 32] = maddr;
    rvfi_mem_wmask[ch*4 +: 4]  = wm;
  endtask

  task automatic retire(input int ch, input logic [31:0] pc, input logic [31:0] insn);
    set_ch(ch, 1'b1, 1'b0, pc, insn, 32'h0, 4'h0);
  endtask

  task automatic store(input int ch, input logic [31:0] maddr, input logic [3:0] wm);
    set_ch(ch, 1'b1, 1'b0, 32'h300, SW, maddr, wm);
  endtask

  // Apply the driven channels at the next edge, then return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic do_reset(input logic [31:0] a0, input logic [31:0] a1);
    resetn    = 1'b0;
    slot_addr = {a1, a0};
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    clr();
    slot_addr = '0;

    // Reset state
    do_reset(32'h100, 32'h200);
    check("rst_state", slot_state, 4'b0000);
    check("rst_data", slot_data, 32'h0);
    check("rst_mismatch", mismatch, 2'b00);
    check("rst_count", check_count, 16'd0);

    // Learn, then matching compare
    retire(0, 32'h100, NOP); tick();
    check("learn_state", slot_state, 4'b0001);
    check("learn_data", slot_data, 32'h0000_0013);
    check("learn_count", check_count, 16'd0);
    retire(0, 32'h100, NOP); tick();
    check("match_count", check_count, 16'd1);
    check("match_mismatch", mismatch, 2'b00);

    // Differing halfword sets a sticky mismatch, data kept
    retire(0, 32'h100, ADDI1); tick();
    check("mm_flag", mismatch, 2'b01);
    check("mm_data", slot_data, 32'h0000_0013);
    check("mm_count", check_count, 16'd2);
    tick();
    check("mm_sticky", mismatch, 2'b01);
    check("mm_slot1_empty", slot_state[3:2], 2'b00);

    // Upper halfword of a 32-bit insn at pc+2
    do_reset(32'h102, 32'h200);
    check("rst2_mismatch", mismatch, 2'b00);
    retire(0, 32'h100, 32'h00A0_0513); tick();
    check("hi_state", slot_state[1:0], 2'b01);
    check("hi_data", slot_data[15:0], 16'h00A0);
    retire(0, 32'h100, 32'h0000_0001); tick();
    check("rvc_no_cover", check_count, 16'd0);
    retire(0, 32'h102, 32'h0000_00A0); tick();
    check("rvc_direct_cmp", check_count, 16'd1);
    check("rvc_direct_mm", mismatch, 2'b00);

    // Store, stale, FENCE.I, relearn (A0 = 0x102)
    store(0, 32'h100, 4'b0100); tick();
    check("st_stale", slot_state[1:0], 2'b10);
    retire(0, 32'h100, 32'h1234_5513); tick();
    check("stale_no_cmp", check_count, 16'd1);
    check("stale_no_mm", mismatch, 2'b00);
    check("stale_kept", slot_state[1:0], 2'b10);
    retire(0, 32'h300, FENCEI); tick();
    check("fence_empty", slot_state[1:0], 2'b00);
    retire(0, 32'h100, 32'h1234_5513); tick();
    check("relearn_state", slot_state[1:0], 2'b01);
    check("relearn_data", slot_data[15:0], 16'h1234);
    retire(0, 32'h300, FENCEI); tick();
    check("fence_learned", slot_state[1:0], 2'b01);
    store(0, 32'h101, 4'b0001); tick();
    check("st_miss_below", slot_state[1:0], 2'b01);
    store(0, 32'h100, 4'b1000); tick();
    check("st_hit_a_plus1", slot_state[1:0], 2'b10);

    // Two channels in one cycle
    do_reset(32'h100, 32'h200);
    retire(0, 32'h100, NOP); tick();
    store(0, 32'h100, 4'b0001);
    retire(1, 32'h100, ADDI1); tick();
    check("st_then_cov_state", slot_state[1:0], 2'b10);
    check("st_then_cov_mm", mismatch, 2'b00);
    check("st_then_cov_cnt", check_count, 16'd0);
    retire(0, 32'h300, FENCEI); tick();
    check("fence2_empty", slot_state[1:0], 2'b00);
    retire(0, 32'h100, NOP);
    retire(1, 32'h100, ADDI1); tick();
    check("learn_cmp_state", slot_state[1:0], 2'b01);
    check("learn_cmp_data", slot_data[15:0], 16'h0013);
    check("learn_cmp_mm", mismatch, 2'b01);
    check("learn_cmp_cnt", check_count, 16'd1);
    retire(1, 32'h1FE, 32'hABCD_0013); tick();
    check("ch1_slot1_state", slot_state[3:2], 2'b01);
    check("ch1_slot1_data", slot_data[31:16], 16'hABCD);

    // Cover then store of the same slot by one instruction
    do_reset(32'h100, 32'h200);
    retire(0, 32'h100, NOP); tick();
    set_ch(0, 1'b1, 1'b0, 32'h100, NOP, 32'h100, 4'b0011); tick();
    check("self_st_cnt", check_count, 16'd1);
    check("self_st_state", slot_state[1:0], 2'b10);
    check("self_st_mm", mismatch, 2'b00);

    // Trap, invalid, reset mid-run, saturation
    do_reset(32'h100, 32'h200);
    set_ch(0, 1'b1, 1'b1, 32'h100, NOP, 32'h0, 4'h0); tick();
    check("trap_no_learn", slot_state, 4'b0000);
    set_ch(0, 1'b0, 1'b0, 32'h100, NOP, 32'h0, 4'h0); tick();
    check("invalid_no_learn", slot_state, 4'b0000);
    retire(0, 32'h100, NOP); tick();
    retire(0, 32'h100, NOP); tick();
    check("pre_rst_cnt", check_count, 16'd1);
    do_reset(32'h100, 32'h200);
    check("midrst_state", slot_state, 4'b0000);
    check("midrst_cnt", check_count, 16'd0);
    retire(0, 32'h100, NOP); tick();
    for (int i = 0; i < 5; i++) begin
      retire(0, 32'h100, NOP); tick();
    end
    check("cnt16_five", check_count, 16'd5);
    check("cnt2_saturate", n1_count, 2'd3);
    check("sat_mm", n1_mismatch, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
